fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction-fetch front end for the 4-stage core. It generates sequential fetch addresses, issues reads to a synchronous instruction memory, and buffers returned words with their PCs in a small FIFO. It presents the head entry to decode as PCF/instructionF and stops on decode stall. A taken branch resolved in decode flushes it and restarts fetch at the branch target.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16; sustains one instruction per cycle when DEPTH >= 3.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP, 32'h6800_0000, instruction word driven while the queue is empty.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- imem_req  out  1  read request this cycle.
- imem_addr  out  32  byte address of the request, always word aligned.
- imem_rdata  in  32  read data, valid exactly one cycle after a request.
- stall  in  1  decode cannot accept the head entry this cycle.
- redirect  in  1  taken branch in decode (isBranchTakenD).
- redirect_pc  in  32  branch target (branchPCD); bits [1:0] are ignored.
- PCF  out  32  PC of the head entry; fetch PC while the queue is empty.
- instructionF  out  32  head instruction; NOP while the queue is empty.
- validF  out  1  head entry is valid.
- count  out  clog2(DEPTH)+1  current occupancy.

## Operation
- State: fetch PC `fpc`, one-bit `inflight`, a FIFO of {pc, instr} entries with read/write pointers, and `count`.
- Request rule: `imem_req = !redirect && (count + inflight < DEPTH)`. `imem_addr = fpc`. On a request, `fpc <= fpc + 4`, which wraps from 32'hFFFF_FFFC to 0.
- `inflight <= imem_req` every cycle. When `inflight` = 1, push {pc_of_request, imem_rdata} at the clock edge, unless `redirect` is high.
- Pop when `validF && !stall && !redirect`.
- Push and pop may occur in the same cycle. Count is then unchanged, and a full queue cannot overflow because the request rule reserves a slot.
- Redirect has highest priority:
  - the queue is cleared (pointers and count go to 0);
  - any response arriving in the same cycle is discarded;
  - no request is issued that cycle;
  - `fpc <= {redirect_pc[31:2], 2'b00}`.
- A redirect while `stall` is high still flushes.
- Outputs are combinational from the head entry. When empty: `validF` = 0, `instructionF` = NOP, `PCF` = `fpc`.

## Timing
- Reset values (asynchronous): `fpc` = RESET_PC, queue empty, `inflight` = 0.
  - While `reset` is low: `imem_req` = 0, `imem_addr` = RESET_PC, `validF` = 0, `instructionF` = NOP, `PCF` = RESET_PC, `count` = 0.
- After reset deasserts (cycle 0):
  - `imem_req` = 1 with `addr` = RESET_PC in cycle 0;
  - data returns in cycle 1;
  - `validF` = 1 with `PCF` = RESET_PC in cycle 2.
  - The load-to-use latency is 2 cycles and there is no bypass.
- Steady state with no stall and DEPTH >= 3: one pop per cycle, consecutive PCs.
- Redirect asserted in cycle r:
  - the request for the target goes out in cycle r+1;
  - the target is at the head with `validF` = 1 in cycle r+3;
  - `validF` = 0 in cycles r+1 and r+2.
- Stall held: requests continue until `count + inflight` = DEPTH, then `imem_req` = 0.
  - After stall drops, the first pop happens that cycle and a new request issues the following cycle.
- Reset asserted mid-operation: all state returns to reset values immediately. An in-flight response is never pushed.

## Test plan
- Reset then free run, with memory returning instr = addr ^ 32'hA5A5_0000.
  - Expect `validF` rising in cycle 2, PCF sequence 0, 4, 8, 12, … one per cycle, and matching instructionF.
- Hold `stall` from cycle 3 for 10 cycles (DEPTH = 4).
  - Expect `count` to saturate at 4 and `imem_req` = 0 with no lost or duplicated PCs.
  - After release, expect the PC order to continue contiguously.
- Redirect to 32'h0000_0103 in cycle 6 of a free run.
  - Expect `imem_addr` = 32'h100 in cycle 7 and PCF = 32'h100 with `validF` in cycle 9.
  - Expect no instruction from the old stream to be popped after cycle 5.
- Redirect while the queue is full and stalled.
  - Expect `count` = 0 the next cycle, the stale response dropped, and the target arriving 3 cycles later.
- Reset with RESET_PC = 32'hFFFF_FFF8.
  - Expect the PCF sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert `reset` low asynchronously mid-clock while `count` = 3 and a request is in flight.
  - Expect `validF`, `count` and `imem_req` to go to 0 immediately, and a restart at RESET_PC after release.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential fetch into a synchronous imem, responses buffered
// with their PCs in a small FIFO, presented to decode; a taken branch flushes and refetches.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h6800_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              PCF,
  output logic [31:0]              instructionF,
  output logic                     validF,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fpc;
  logic [31:0]   reqPc;
  logic          inflight;
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [CW-1:0] countQ;
  logic [31:0]   pcMem    [DEPTH];
  logic [31:0]   instrMem [DEPTH];

  logic [CW:0]   pending;
  logic [31:0]   targetPc;
  logic          push;
  logic          pop;

  // Occupancy plus the outstanding response reserves a slot so a push can never overflow.
  always_comb begin
    pending   = (CW+1)'(countQ) + (CW+1)'(inflight);
    targetPc  = redirect_pc & ~32'h0000_0003;
    imem_req  = reset && !redirect && (pending < (CW+1)'(DEPTH));
    imem_addr = fpc;
    validF    = (countQ != '0);
    push      = inflight && !redirect;
    pop       = validF && !stall && !redirect;
  end

  always_comb begin
    PCF          = fpc;
    instructionF = NOP;
    if (validF) begin
      PCF          = pcMem[rdPtr];
      instructionF = instrMem[rdPtr];
    end
  end

  assign count = countQ;

  // Fetch PC and the single outstanding request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc      <= RESET_PC;
      reqPc    <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) reqPc <= fpc;
      if (redirect)      fpc <= targetPc;
      else if (imem_req) fpc <= fpc + 32'd4;
    end
  end

  // Queue pointers and occupancy; redirect clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      countQ <= '0;
    end else if (redirect) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      countQ <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   countQ <= countQ + CW'(1);
        2'b01:   countQ <= countQ - CW'(1);
        default: countQ <= countQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtr]    <= reqPc;
      instrMem[wrPtr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: free run, stall backpressure, redirects, PC wrap, async reset.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;

  logic        imemReq,   imemReq2;
  logic [31:0] imemAddr,  imemAddr2;
  logic [31:0] imemRdata, imemRdata2;
  logic [31:0] pcF,       pcF2;
  logic [31:0] instrF,    instrF2;
  logic        validF,    validF2;
  logic [2:0]  count,     count2;

  int nTests = 0;
  int nFail  = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000), .NOP(32'h6800_0000)) u_dut (
    .clk(clk), .reset(reset), .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_rdata(imemRdata), .stall(stall), .redirect(redirect), .redirect_pc(redirectPc),
    .PCF(pcF), .instructionF(instrF), .validF(validF), .count(count)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .NOP(32'h6800_0000)) u_dut2 (
    .clk(clk), .reset(reset), .imem_req(imemReq2), .imem_addr(imemAddr2),
    .imem_rdata(imemRdata2), .stall(stall), .redirect(redirect), .redirect_pc(redirectPc),
    .PCF(pcF2), .instructionF(instrF2), .validF(validF2), .count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: word = addr ^ A5A5_0000, garbage when not requested.
  always @(posedge clk) begin
    imemRdata  <= imemReq  ? (imemAddr  ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    imemRdata2 <= imemReq2 ? (imemAddr2 ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
  end

  // Leaves the bench at the sample point of cycle 0 after release.
  task automatic applyReset();
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic cyc(input logic s, input logic r, input logic [31:0] rpc);
    @(negedge clk);
    stall = s; redirect = r; redirectPc = rpc;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = '0;
    @(negedge clk); #1;
    nTests++; if (imemReq !== 1'b0) begin nFail++; $display("FAIL rst_req got %0b exp 0", imemReq); end
    nTests++; if (imemAddr !== 32'h0) begin nFail++; $display("FAIL rst_addr got %h exp 00000000", imemAddr); end
    nTests++; if (validF !== 1'b0) begin nFail++; $display("FAIL rst_valid got %0b exp 0", validF); end
    nTests++; if (instrF !== 32'h6800_0000) begin nFail++; $display("FAIL rst_instr got %h exp 68000000", instrF); end
    nTests++; if (pcF !== 32'h0) begin nFail++; $display("FAIL rst_pcf got %h exp 00000000", pcF); end
    nTests++; if (count !== 3'd0) begin nFail++; $display("FAIL rst_count got %0d exp 0", count); end
    nTests++; if (pcF2 !== 32'hFFFF_FFF8) begin nFail++; $display("FAIL rst_pcf2 got %h exp fffffff8", pcF2); end
  endtask

  task automatic test_free_run();
    logic [31:0] exp;
    applyReset();
    nTests++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin nFail++;
      $display("FAIL run_c0_req got req=%0b addr=%h exp req=1 addr=00000000", imemReq, imemAddr); end
    cyc(1'b0, 1'b0, '0);
    nTests++; if (validF !== 1'b0) begin nFail++; $display("FAIL run_c1_valid got %0b exp 0", validF); end
    for (int k = 2; k <= 9; k++) begin
      cyc(1'b0, 1'b0, '0);
      exp = 32'((k - 2) * 4);
      nTests++; if (validF !== 1'b1 || pcF !== exp || instrF !== (exp ^ 32'hA5A5_0000)) begin nFail++;
        $display("FAIL run_c%0d got v=%0b pc=%h ins=%h exp v=1 pc=%h ins=%h", k, validF, pcF, instrF, exp, exp ^ 32'hA5A5_0000); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    applyReset();
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    nTests++; if (pcF !== 32'h0) begin nFail++; $display("FAIL stall_c2_pc got %h exp 00000000", pcF); end
    for (int k = 3; k <= 12; k++) begin
      cyc(1'b1, 1'b0, '0);
      nTests++; if (pcF !== 32'h4 || validF !== 1'b1) begin nFail++;
        $display("FAIL stall_hold_c%0d got v=%0b pc=%h exp v=1 pc=00000004", k, validF, pcF); end
      if (k >= 6) begin
        nTests++; if (count !== 3'd4 || imemReq !== 1'b0) begin nFail++;
          $display("FAIL stall_full_c%0d got count=%0d req=%0b exp count=4 req=0", k, count, imemReq); end
      end
    end
    for (int k = 13; k <= 20; k++) begin
      cyc(1'b0, 1'b0, '0);
      exp = 32'(4 + 4 * (k - 13));
      nTests++; if (validF !== 1'b1 || pcF !== exp || instrF !== (exp ^ 32'hA5A5_0000)) begin nFail++;
        $display("FAIL stall_rel_c%0d got v=%0b pc=%h exp v=1 pc=%h", k, validF, pcF, exp); end
      if (k == 13) begin
        nTests++; if (imemReq !== 1'b0) begin nFail++; $display("FAIL stall_c13_req got %0b exp 0", imemReq); end
      end
      if (k == 14) begin
        nTests++; if (imemReq !== 1'b1 || imemAddr !== 32'h14) begin nFail++;
          $display("FAIL stall_c14_req got req=%0b addr=%h exp req=1 addr=00000014", imemReq, imemAddr); end
      end
    end
  endtask

  task automatic test_redirect();
    applyReset();
    for (int k = 1; k <= 5; k++) cyc(1'b0, 1'b0, '0);
    nTests++; if (pcF !== 32'hC) begin nFail++; $display("FAIL redir_c5_pc got %h exp 0000000c", pcF); end
    cyc(1'b0, 1'b1, 32'h0000_0103);
    nTests++; if (imemReq !== 1'b0) begin nFail++; $display("FAIL redir_c6_req got %0b exp 0", imemReq); end
    cyc(1'b0, 1'b0, '0);
    nTests++; if (imemReq !== 1'b1 || imemAddr !== 32'h100 || validF !== 1'b0 || count !== 3'd0) begin nFail++;
      $display("FAIL redir_c7 got req=%0b addr=%h v=%0b cnt=%0d exp req=1 addr=00000100 v=0 cnt=0", imemReq, imemAddr, validF, count); end
    cyc(1'b0, 1'b0, '0);
    nTests++; if (validF !== 1'b0 || imemAddr !== 32'h104) begin nFail++;
      $display("FAIL redir_c8 got v=%0b addr=%h exp v=0 addr=00000104", validF, imemAddr); end
    cyc(1'b0, 1'b0, '0);
    nTests++; if (validF !== 1'b1 || pcF !== 32'h100 || instrF !== 32'hA5A5_0100) begin nFail++;
      $display("FAIL redir_c9 got v=%0b pc=%h ins=%h exp v=1 pc=00000100 ins=a5a50100", validF, pcF, instrF); end
    cyc(1'b0, 1'b0, '0);
    nTests++; if (validF !== 1'b1 || pcF !== 32'h104) begin nFail++;
      $display("FAIL redir_c10 got v=%0b pc=%h exp v=1 pc=00000104", validF, pcF); end
  endtask

  task automatic test_redirect_full();
    applyReset();
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    for (int k = 3; k <= 7; k++) cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 32'h0000_0200);
    nTests++; if (count !== 3'd4 || imemReq !== 1'b0) begin nFail++;
      $display("FAIL rfull_c8 got cnt=%0d req=%0b exp cnt=4 req=0", count, imemReq); end
    cyc(1'b1, 1'b0, '0);
    nTests++; if (count !== 3'd0 || validF !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h200) begin nFail++;
      $display("FAIL rfull_c9 got cnt=%0d v=%0b req=%0b addr=%h exp cnt=0 v=0 req=1 addr=00000200", count, validF, imemReq, imemAddr); end
    cyc(1'b1, 1'b0, '0);
    nTests++; if (validF !== 1'b0) begin nFail++; $display("FAIL rfull_c10_valid got %0b exp 0", validF); end
    cyc(1'b1, 1'b0, '0);
    nTests++; if (validF !== 1'b1 || pcF !== 32'h200 || instrF !== 32'hA5A5_0200) begin nFail++;
      $display("FAIL rfull_c11 got v=%0b pc=%h ins=%h exp v=1 pc=00000200 ins=a5a50200", validF, pcF, instrF); end
    cyc(1'b1, 1'b0, '0);
    nTests++; if (count !== 3'd2 || pcF !== 32'h200) begin nFail++;
      $display("FAIL rfull_c12 got cnt=%0d pc=%h exp cnt=2 pc=00000200", count, pcF); end
  endtask

  task automatic test_wrap();
    logic [31:0] expSeq [4];
    expSeq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    applyReset();
    nTests++; if (imemReq2 !== 1'b1 || imemAddr2 !== 32'hFFFF_FFF8) begin nFail++;
      $display("FAIL wrap_c0 got req=%0b addr=%h exp req=1 addr=fffffff8", imemReq2, imemAddr2); end
    cyc(1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, '0);
      nTests++; if (validF2 !== 1'b1 || pcF2 !== expSeq[k] || instrF2 !== (expSeq[k] ^ 32'hA5A5_0000)) begin nFail++;
        $display("FAIL wrap_seq%0d got v=%0b pc=%h exp v=1 pc=%h", k, validF2, pcF2, expSeq[k]); end
    end
  endtask

  task automatic test_async_reset();
    applyReset();
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    for (int k = 3; k <= 5; k++) cyc(1'b1, 1'b0, '0);
    nTests++; if (count !== 3'd3) begin nFail++; $display("FAIL arst_pre_count got %0d exp 3", count); end
    #2 reset = 1'b0;
    #1;
    nTests++; if (validF !== 1'b0 || count !== 3'd0 || imemReq !== 1'b0 || pcF !== 32'h0) begin nFail++;
      $display("FAIL arst_now got v=%0b cnt=%0d req=%0b pc=%h exp v=0 cnt=0 req=0 pc=00000000", validF, count, imemReq, pcF); end
    @(negedge clk);
    stall = 1'b0; reset = 1'b1;
    #1;
    nTests++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin nFail++;
      $display("FAIL arst_c0 got req=%0b addr=%h exp req=1 addr=00000000", imemReq, imemAddr); end
    cyc(1'b0, 1'b0, '0);
    nTests++; if (validF !== 1'b0 || count !== 3'd0) begin nFail++;
      $display("FAIL arst_c1 got v=%0b cnt=%0d exp v=0 cnt=0", validF, count); end
    cyc(1'b0, 1'b0, '0);
    nTests++; if (validF !== 1'b1 || pcF !== 32'h0 || instrF !== 32'hA5A5_0000) begin nFail++;
      $display("FAIL arst_c2 got v=%0b pc=%h ins=%h exp v=1 pc=00000000 ins=a5a50000", validF, pcF, instrF); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = '0;
    #3;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_full();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
